// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - cache request port types and geometry shared with the store drain
package ariane_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

endpackage

// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - store drain entry/state types and tail-merge helper
package std_cache_pkg;

  localparam int unsigned STORE_PADDR_W = 56;

  typedef enum logic [1:0] {IDLE, REQ, TAG} drain_state_e;

  typedef struct packed {
    logic [STORE_PADDR_W-1:0] paddr;
    logic [63:0]              data;
    logic [7:0]               be;
    logic [1:0]               size;
  } store_drain_entry_t;

  // Newer bytes win; the merged entry always becomes a full doubleword access.
  function automatic store_drain_entry_t merge_store(input store_drain_entry_t old_e,
                                                     input store_drain_entry_t new_e);
    store_drain_entry_t res;
    res = old_e;
    for (int i = 0; i < 8; i++) begin
      if (new_e.be[i]) res.data[8*i +: 8] = new_e.data[8*i +: 8];
    end
    res.be   = old_e.be | new_e.be;
    res.size = 2'd3;
    return res;
  endfunction

endpackage

// File: rtl/dcache_store_fifo.sv
// rtl/dcache_store_fifo.sv - committed-store FIFO; tail merge when DCACHE_STORE_DRAIN_MERGE_EN
module dcache_store_fifo
  import std_cache_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  store_drain_entry_t push_entry_i,
  input  logic               pop_i,
`ifdef DCACHE_STORE_DRAIN_MERGE_EN
  input  logic               head_busy_i,
`endif
  output store_drain_entry_t head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               merge_hit_o,
  output logic               nonempty_next_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  store_drain_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]               rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PTR_W:0]                 count_q, count_d;
  logic                           alloc;

`ifdef DCACHE_STORE_DRAIN_MERGE_EN
  logic [PTR_W-1:0] tail_idx;
  assign tail_idx = wptr_q - 1'b1;
  // The head is frozen once the FSM has started presenting it to the cache.
  assign merge_hit_o = (count_q != '0)
                    && (mem_q[tail_idx].paddr[STORE_PADDR_W-1:3] == push_entry_i.paddr[STORE_PADDR_W-1:3])
                    && !(head_busy_i && (tail_idx == rptr_q));
`else
  assign merge_hit_o = 1'b0;
`endif

  assign alloc           = push_i & ~merge_hit_o;
  assign head_o          = mem_q[rptr_q];
  assign full_o          = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o         = (count_q == '0);
  assign nonempty_next_o = (count_d != '0);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (alloc) begin
      mem_d[wptr_q] = push_entry_i;
      wptr_d        = wptr_q + 1'b1;
    end
`ifdef DCACHE_STORE_DRAIN_MERGE_EN
    if (push_i && merge_hit_o) mem_d[tail_idx] = merge_store(mem_q[tail_idx], push_entry_i);
`endif
    if (pop_i) rptr_d = rptr_q + 1'b1;
    count_d = count_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dcache_store_drain.sv
// rtl/dcache_store_drain.sv - committed-store buffer draining into a dcache store port; DCACHE_STORE_DRAIN_MERGE_EN
module dcache_store_drain
  import ariane_pkg::*;
  import std_cache_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PADDR_W = STORE_PADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_valid_i,
  output logic               push_ready_o,
  input  logic [PADDR_W-1:0] push_paddr_i,
  input  logic [63:0]        push_data_i,
  input  logic [7:0]         push_be_i,
  input  logic [1:0]         push_size_i,
  output logic               empty_o,
  output dcache_req_i_t      req_port_o,
  input  dcache_req_o_t      req_port_i
);

  drain_state_e       state_q, state_d;
  store_drain_entry_t head, push_entry;
  logic               fifo_full, fifo_empty, merge_hit, nonempty_next;
  logic               push, pop;
  logic               unused_rsp;

  assign unused_rsp = ^{req_port_i.data_rvalid, req_port_i.data_rdata};

  assign push_entry = '{paddr: STORE_PADDR_W'(push_paddr_i), data: push_data_i,
                        be: push_be_i, size: push_size_i};

  assign push_ready_o = rst_ni & ~flush_i & (~fifo_full | merge_hit);
  assign push         = push_valid_i & push_ready_o;
  assign pop          = (state_q == TAG);
  assign empty_o      = fifo_empty & (state_q == IDLE);

  dcache_store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .push_i          (push),
    .push_entry_i    (push_entry),
    .pop_i           (pop),
`ifdef DCACHE_STORE_DRAIN_MERGE_EN
    .head_busy_i     (state_q != IDLE),
`endif
    .head_o          (head),
    .full_o          (fifo_full),
    .empty_o         (fifo_empty),
    .merge_hit_o     (merge_hit),
    .nonempty_next_o (nonempty_next)
  );

  always_comb begin
    state_d    = state_q;
    req_port_o = '0;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = REQ;
      REQ: begin
        req_port_o.data_req      = 1'b1;
        req_port_o.data_we       = 1'b1;
        req_port_o.address_index = head.paddr[DCACHE_INDEX_WIDTH-1:0];
        req_port_o.data_wdata    = head.data;
        req_port_o.data_be       = head.be;
        req_port_o.data_size     = head.size;
        if (req_port_i.data_gnt) state_d = TAG;
      end
      TAG: begin
        req_port_o.tag_valid   = 1'b1;
        req_port_o.address_tag = head.paddr[DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:DCACHE_INDEX_WIDTH];
        state_d = nonempty_next ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Nothing may reach the cache while reset is held, including a pending tag phase.
    if (!rst_ni) req_port_o = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

endmodule
